// File: rtl/traffic_signal_timed_if.sv
// traffic_signal_timed_if
//   Groups the intersection sensor inputs and lamp-driver outputs into one bus.
//   master : sensor/lamp-driver side (drives X, ped_req; receives lamps)
//   slave  : controller side (receives X, ped_req; drives lamps and phase)
//   X        country-road vehicle present (level)
//   ped_req  pedestrian crossing request (pulse or level)
//   hwy      highway lamp, 2'd0 RED / 2'd1 YELLOW / 2'd2 GREEN
//   cny      country lamp, same encoding
//   walk     pedestrian walk lamp
//   phase    current controller state code, debug only
interface traffic_signal_timed_if;
   logic       X;
   logic       ped_req;
   logic [1:0] hwy;
   logic [1:0] cny;
   logic       walk;
   logic [2:0] phase;

   modport master (
      output X,
      output ped_req,
      input  hwy,
      input  cny,
      input  walk,
      input  phase
   );

   modport slave (
      input  X,
      input  ped_req,
      output hwy,
      output cny,
      output walk,
      output phase
   );
endinterface

// File: rtl/traffic_signal_timed.sv
// traffic_signal_timed
//   Highway/country-road intersection controller with a dwell timer, highway
//   minimum green, country maximum green, all-red clearance both ways and a
//   latched pedestrian walk phase served during country green.
//   clk    system clock, all state on the rising edge
//   reset  synchronous, active-high
//   bus    slave side of traffic_signal_timed_if (X, ped_req in; hwy, cny,
//          walk, phase out). Outputs are a Moore decode of registered state.
module traffic_signal_timed #(
   parameter int unsigned Y2R_DELAY     = 2,
   parameter int unsigned R2G_DELAY     = 3,
   parameter int unsigned HWY_MIN_GREEN = 4,
   parameter int unsigned CNY_MAX_GREEN = 8,
   parameter int unsigned PED_WALK      = 5,
   parameter int unsigned TW            = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   traffic_signal_timed_if.slave bus
);

   localparam logic [2:0] S0_HWY_GREEN   = 3'd0;
   localparam logic [2:0] S1_HWY_YELLOW  = 3'd1;
   localparam logic [2:0] S2_ALL_RED_CNY = 3'd2;
   localparam logic [2:0] S3_CNY_GREEN   = 3'd3;
   localparam logic [2:0] S4_CNY_YELLOW  = 3'd4;
   localparam logic [2:0] S5_ALL_RED_HWY = 3'd5;

   localparam logic [1:0] RED    = 2'd0;
   localparam logic [1:0] YELLOW = 2'd1;
   localparam logic [1:0] GREEN  = 2'd2;

   // Timer value seen during the last cycle of each timed phase.
   localparam logic [TW-1:0] Y2R_LAST     = TW'(Y2R_DELAY - 1);
   localparam logic [TW-1:0] R2G_LAST     = TW'(R2G_DELAY - 1);
   localparam logic [TW-1:0] HWY_MIN_LAST = TW'(HWY_MIN_GREEN - 1);
   localparam logic [TW-1:0] CNY_MAX_LAST = TW'(CNY_MAX_GREEN - 1);
   localparam logic [TW-1:0] PED_LAST     = TW'(PED_WALK - 1);

   logic [2:0]    state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          ped_pending_q, ped_pending_d;
   logic          walk_active_q, walk_active_d;
   logic          enter_cny, leave_cny;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S0_HWY_GREEN:
            if ((timer_q >= HWY_MIN_LAST) && (bus.X || ped_pending_q))
               state_d = S1_HWY_YELLOW;
         S1_HWY_YELLOW:
            if (timer_q == Y2R_LAST) state_d = S2_ALL_RED_CNY;
         S2_ALL_RED_CNY:
            if (timer_q == R2G_LAST) state_d = S3_CNY_GREEN;
         S3_CNY_GREEN: begin
            // Max green forces exit; otherwise leave once traffic is gone,
            // unless a walk is still inside its minimum time.
            if (timer_q == CNY_MAX_LAST)
               state_d = S4_CNY_YELLOW;
            else if (!bus.X && !(walk_active_q && (timer_q < PED_LAST)))
               state_d = S4_CNY_YELLOW;
         end
         S4_CNY_YELLOW:
            if (timer_q == Y2R_LAST) state_d = S5_ALL_RED_HWY;
         S5_ALL_RED_HWY:
            if (timer_q == R2G_LAST) state_d = S0_HWY_GREEN;
         default:
            state_d = S0_HWY_GREEN;
      endcase
   end

   assign enter_cny = (state_q == S2_ALL_RED_CNY) && (state_d == S3_CNY_GREEN);
   assign leave_cny = (state_q == S3_CNY_GREEN) && (state_d != S3_CNY_GREEN);

   always_comb begin
      timer_d = '0;
      if (state_d == state_q)
         timer_d = (timer_q == '1) ? timer_q : timer_q + 1'b1;
   end

   // A request landing on the S2->S3 edge is folded straight into this walk;
   // one landing during S3 stays pending for the next country phase.
   always_comb begin
      ped_pending_d = ped_pending_q | bus.ped_req;
      walk_active_d = walk_active_q;
      if (enter_cny) begin
         walk_active_d = ped_pending_q | bus.ped_req;
         ped_pending_d = 1'b0;
      end else if (leave_cny) begin
         walk_active_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S0_HWY_GREEN;
         timer_q       <= '0;
         ped_pending_q <= 1'b0;
         walk_active_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         ped_pending_q <= ped_pending_d;
         walk_active_q <= walk_active_d;
      end
   end

   always_comb begin
      bus.hwy   = RED;
      bus.cny   = RED;
      bus.walk  = 1'b0;
      bus.phase = state_q;
      case (state_q)
         S0_HWY_GREEN:  bus.hwy = GREEN;
         S1_HWY_YELLOW: bus.hwy = YELLOW;
         S3_CNY_GREEN: begin
            bus.cny  = GREEN;
            bus.walk = walk_active_q;
         end
         S4_CNY_YELLOW: bus.cny = YELLOW;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_traffic_signal_timed.sv
module tb_traffic_signal_timed;

   localparam int Y2R  = 2;
   localparam int R2G  = 3;
   localparam int HMIN = 4;
   localparam int CMAX = 8;
   localparam int PW   = 5;

   logic clk;
   logic reset;
   traffic_signal_timed_if bus();

   traffic_signal_timed #(
      .Y2R_DELAY     (Y2R),
      .R2G_DELAY     (R2G),
      .HWY_MIN_GREEN (HMIN),
      .CNY_MAX_GREEN (CMAX),
      .PED_WALK      (PW),
      .TW            (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: phase number, cycles already spent in it, pedestrian flags.
   int m_ph = 0;
   int m_t  = 0;
   bit m_pend = 0;
   bit m_wa   = 0;

   task automatic model_update(input bit r, input bit x, input bit p);
      bit adv;
      if (r) begin
         m_ph = 0; m_t = 0; m_pend = 0; m_wa = 0;
         return;
      end
      case (m_ph)
         0:       adv = (m_t + 1 >= HMIN) && (x || m_pend);
         1, 4:    adv = (m_t + 1 == Y2R);
         2, 5:    adv = (m_t + 1 == R2G);
         3:       adv = (m_t + 1 == CMAX) || (!x && !(m_wa && (m_t + 1 < PW)));
         default: adv = 1;
      endcase
      if (m_ph == 2 && adv) begin
         m_wa   = m_pend || p;
         m_pend = 0;
      end else if (p) begin
         m_pend = 1;
      end
      if (m_ph == 3 && adv) m_wa = 0;
      if (adv) begin
         m_ph = (m_ph + 1) % 6;
         m_t  = 0;
      end else if (m_t < 255) begin
         m_t++;
      end
   endtask

   function automatic logic [7:0] exp_out();
      logic [1:0] h, c;
      h = (m_ph == 0) ? 2'd2 : (m_ph == 1) ? 2'd1 : 2'd0;
      c = (m_ph == 3) ? 2'd2 : (m_ph == 4) ? 2'd1 : 2'd0;
      return {3'(m_ph), h, c, (m_ph == 3) && m_wa};
   endfunction

   function automatic logic [7:0] obs();
      return {bus.phase, bus.hwy, bus.cny, bus.walk};
   endfunction

   // Drive inputs away from the edge, clock once, advance the model, sample at +1.
   task automatic step(input bit r, input bit x, input bit p);
      reset = r; bus.X = x; bus.ped_req = p;
      @(posedge clk);
      model_update(r, x, p);
      #1;
   endtask

   task automatic do_reset(input bit x);
      step(1, x, 0);
      step(1, x, 0);
   endtask

   task automatic test_reset;
      for (int i = 0; i < 3; i++) begin
         step(1, 1, 0);
         n_vec++;
         if (obs() !== 8'b000_10_00_0) begin
            n_err++;
            $display("FAIL reset_hold: got %b expected %b", obs(), 8'b000_10_00_0);
         end
      end
      for (int i = 1; i <= 4; i++) begin
         step(0, 1, 0);
         n_vec++;
         if (obs() !== exp_out()) begin
            n_err++;
            $display("FAIL reset_release cycle %0d: got %b expected %b", i, obs(), exp_out());
         end
         if (i == 3 || i == 4) begin
            n_vec++;
            if (bus.phase !== ((i == 4) ? 3'd1 : 3'd0)) begin
               n_err++;
               $display("FAIL reset_min_green cycle %0d: phase %0d expected %0d", i, bus.phase, (i == 4) ? 1 : 0);
            end
         end
      end
   endtask

   task automatic test_starvation;
      int q[$];
      int runs_len[$];
      int runs_ph[$];
      int exp_len[6] = '{4, 2, 3, 8, 2, 3};
      int run;
      do_reset(1);
      q.push_back(int'(bus.phase));
      for (int i = 0; i < 50; i++) begin
         step(0, 1, 0);
         n_vec++;
         if (obs() !== exp_out()) begin
            n_err++;
            $display("FAIL starve cycle %0d: got %b expected %b", i, obs(), exp_out());
         end
         q.push_back(int'(bus.phase));
      end
      run = 1;
      for (int i = 1; i < q.size(); i++) begin
         if (q[i] == q[i-1]) run++;
         else begin
            runs_len.push_back(run);
            runs_ph.push_back(q[i-1]);
            run = 1;
         end
      end
      for (int k = 0; k < 12; k++) begin
         n_vec++;
         if (k >= runs_len.size() || runs_len[k] != exp_len[k % 6] || runs_ph[k] != k % 6) begin
            n_err++;
            $display("FAIL starve_run %0d: got phase %0d len %0d expected phase %0d len %0d", k,
                     (k < runs_ph.size()) ? runs_ph[k] : -1,
                     (k < runs_len.size()) ? runs_len[k] : -1, k % 6, exp_len[k % 6]);
         end
      end
   endtask

   task automatic test_early_release;
      bit released = 0;
      int s3cnt = 0;
      do_reset(1);
      for (int i = 0; i < 40; i++) begin
         if (m_ph == 3 && m_t == 2) released = 1;
         step(0, !released, 0);
         n_vec++;
         if (obs() !== exp_out()) begin
            n_err++;
            $display("FAIL early cycle %0d: got %b expected %b", i, obs(), exp_out());
         end
         if (bus.phase === 3'd3) s3cnt++;
      end
      n_vec++;
      if (s3cnt != 3) begin
         n_err++;
         $display("FAIL early_s3_len: got %0d expected 3", s3cnt);
      end
      n_vec++;
      if (bus.phase !== 3'd0) begin
         n_err++;
         $display("FAIL early_hold_s0: phase %0d expected 0", bus.phase);
      end
   endtask

   task automatic test_ped_only;
      int first_s1 = -1;
      int s3cnt = 0, walkcnt = 0, s4walk = 0;
      do_reset(0);
      for (int i = 1; i <= 45; i++) begin
         step(0, 0, i == 10);
         n_vec++;
         if (obs() !== exp_out()) begin
            n_err++;
            $display("FAIL ped cycle %0d: got %b expected %b", i, obs(), exp_out());
         end
         if (bus.phase === 3'd1 && first_s1 < 0) first_s1 = i;
         if (bus.phase === 3'd3) s3cnt++;
         if (bus.phase === 3'd3 && bus.walk === 1'b1) walkcnt++;
         if (bus.phase === 3'd4 && bus.walk !== 1'b0) s4walk++;
      end
      n_vec++;
      if (first_s1 != 11) begin
         n_err++;
         $display("FAIL ped_s1_cycle: got %0d expected 11", first_s1);
      end
      n_vec++;
      if (s3cnt != PW || walkcnt != PW) begin
         n_err++;
         $display("FAIL ped_walk_len: s3 %0d walk %0d expected %0d", s3cnt, walkcnt, PW);
      end
      n_vec++;
      if (s4walk != 0) begin
         n_err++;
         $display("FAIL ped_walk_s4: got %0d expected 0", s4walk);
      end
      n_vec++;
      if (bus.phase !== 3'd0) begin
         n_err++;
         $display("FAIL ped_cleared: phase %0d expected 0", bus.phase);
      end
   endtask

   task automatic test_ped_during_s3;
      bit x = 1, seen5 = 0, done = 0;
      int s0cnt = 0, walkcnt = 0;
      do_reset(1);
      for (int i = 0; i < 60; i++) begin
         bit p;
         p = (m_ph == 3 && m_t == 2 && x);
         step(0, x, p);
         if (p) x = 0;
         n_vec++;
         if (obs() !== exp_out()) begin
            n_err++;
            $display("FAIL ped_s3 cycle %0d: got %b expected %b", i, obs(), exp_out());
         end
         if (!x && bus.phase === 3'd5) seen5 = 1;
         if (seen5 && !done && bus.phase === 3'd0) s0cnt++;
         if (seen5 && bus.phase === 3'd1) done = 1;
         if (bus.walk === 1'b1) walkcnt++;
      end
      n_vec++;
      if (s0cnt != HMIN) begin
         n_err++;
         $display("FAIL ped_s3_s0_len: got %0d expected %0d", s0cnt, HMIN);
      end
      n_vec++;
      if (walkcnt != PW) begin
         n_err++;
         $display("FAIL ped_s3_walk: got %0d expected %0d", walkcnt, PW);
      end
   endtask

   task automatic test_reset_mid;
      int s0cnt = 1;
      int guard = 0;
      do_reset(1);
      while (!(m_ph == 2 && m_t == 1) && guard < 30) begin
         step(0, 1, 0);
         guard++;
      end
      n_vec++;
      if (bus.phase !== 3'd2) begin
         n_err++;
         $display("FAIL mid_reach_s2: phase %0d expected 2", bus.phase);
      end
      step(1, 1, 0);
      n_vec++;
      if (obs() !== 8'b000_10_00_0) begin
         n_err++;
         $display("FAIL mid_reset: got %b expected %b", obs(), 8'b000_10_00_0);
      end
      for (int i = 0; i < 10; i++) begin
         step(0, 1, 0);
         if (bus.phase === 3'd0) s0cnt++;
         else break;
      end
      n_vec++;
      if (s0cnt != HMIN) begin
         n_err++;
         $display("FAIL mid_min_green: got %0d expected %0d", s0cnt, HMIN);
      end
   endtask

   task automatic test_random;
      bit x = 0;
      do_reset(0);
      for (int i = 0; i < 4000; i++) begin
         bit p, r;
         if ($urandom_range(0, 5) == 0) x = ~x;
         p = ($urandom_range(0, 19) == 0);
         r = ($urandom_range(0, 199) == 0);
         step(r, x, p);
         n_vec++;
         if (obs() !== exp_out()) begin
            n_err++;
            $display("FAIL random cycle %0d: got %b expected %b", i, obs(), exp_out());
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      bus.X = 1'b0;
      bus.ped_req = 1'b0;
      #2;
      test_reset;
      test_starvation;
      test_early_release;
      test_ped_only;
      test_ped_during_s3;
      test_reset_mid;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
